fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of the byte FIFO among NUM_REQ producers in one clock domain. It grants one requester at a time for a bounded burst and forwards accepted beats straight onto the FIFO wr/data_in pins. It honours the FIFO full flag as backpressure and sits directly in front of the FIFO write side.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, beat width; matches FIFO data_in
MAX_BURST, 4, maximum beats per grant before forced rotation (>=1)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester beat valid
req_last  input  NUM_REQ  per-requester end-of-burst marker, qualified by valid
req_data  input  NUM_REQ*DATA_W  packed beats; requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester accept
fifo_full  input  1  FIFO full flag
fifo_wr  output  1  FIFO write enable
fifo_data_in  output  DATA_W  FIFO write data
grant_id  output  $clog2(NUM_REQ)  current owner, valid while busy=1
busy  output  1  high in BURST state

Behaviour:
- The clock is clk. Reset is reset: synchronous, active-high. Both are fixed for this block.
- Reset values:
  - State IDLE; grant_id=0; last_grant=NUM_REQ-1, so req 0 wins first; beat_cnt=0.
  - req_ready=0, fifo_wr=0, fifo_data_in=0, busy=0.
- States: IDLE and BURST, held in a registered FSM.
- IDLE:
  - req_ready=0.
  - If any req_valid is set, pick the first set bit scanning last_grant+1 upward with wrap.
  - Register the winner into grant_id, clear beat_cnt, go to BURST next cycle.
  - Arbitration latency is one cycle. No beat is accepted in IDLE.
- BURST:
  - req_ready[grant_id] = !fifo_full (combinational). All other ready bits are 0.
  - A beat is accepted when req_valid[g] and req_ready[g] are both high. In that cycle fifo_wr=1 and fifo_data_in=req_data[g], with zero latency.
  - fifo_data_in=0 whenever fifo_wr=0.
  - Each accepted beat increments beat_cnt.
- Exit BURST to IDLE (last_grant<=g) when either:
  - an accepted beat has req_last[g]=1 or beat_cnt==MAX_BURST-1; or
  - req_valid[g]=0, in which case no beat is written that cycle.
- fifo_full while in BURST: stall, state and beat_cnt hold, no timeout. The requester must hold data and last stable while valid and not ready.
- Every grant is followed by exactly one IDLE bubble cycle. Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- beat_cnt width is max(1,$clog2(MAX_BURST)). It never wraps, because it resets on every grant.
- MAX_BURST=1: every accepted beat ends the burst.
- Reset asserted mid-burst: the burst is abandoned, fifo_wr=0 in the reset cycle, and all registers return to reset values next edge.
- A requester that drops valid and later reasserts waits for normal rotation.

Optional Feature:
FIFO_ARB_PRIO_EN
- Defined: in IDLE, requester 0 wins whenever req_valid[0]=1, regardless of the pointer. last_grant updates normally on exit. MAX_BURST still bounds requester 0.
- Undefined: pure round-robin as above, with no priority logic synthesised.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - a localparam function for the grant-id width;
  - a default-data constant (all zeros).
- Sub-module fifo_arb_rr_pick: combinational round-robin picker.
  - Inputs: request vector and last_grant.
  - Outputs: winner index and any_req.
  - The priority override lives in the parent, under the macro.

Test Plan:
- Reset, then req_valid=4'b0001, data 0xA0..0xA3, last on 4th beat:
  - busy rises 1 cycle after valid.
  - 4 consecutive fifo_wr with 0xA0..0xA3.
  - Then IDLE, last_grant=0.
- All four valid continuously, no last, MAX_BURST=4:
  - grant order 0,1,2,3,0.
  - Each grant writes exactly 4 beats followed by one IDLE cycle.
- Grant 2 active, fifo_full=1 for 3 cycles mid-burst:
  - req_ready[2]=0, fifo_wr=0, beat_cnt held.
  - Resumes on full=0 with no lost or duplicated beat.
- Grant 1, req_valid[1] drops after 2 beats:
  - exits to IDLE with 2 writes.
  - Next grant goes to 2 if requester 2 is valid.
- reset=1 during 3rd beat of a burst:
  - fifo_wr=0 that cycle; all outputs zero next cycle.
  - First grant after release goes to requester 0.
- FIFO_ARB_PRIO_EN defined, last_grant=0, requesters 0 and 1 valid:
  - requester 0 is granted again.
  - Undefined build grants requester 1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write arbiter:
//   arb_state_e   - arbiter FSM state (IDLE / BURST)
//   gid_w()       - width of a requester index for a given requester count
//   cnt_w()       - width of the per-grant beat counter for a given burst limit
//   DEF_DATA_BIT  - idle value of every fifo_data_in bit (all zeros)
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Requester index width; never zero even for a single requester.
    function automatic int gid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Beat counter only has to reach MAX_BURST-1, so $clog2(MAX_BURST) bits.
    function automatic int cnt_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam logic DEF_DATA_BIT = 1'b0;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// fifo_arb_rr_pick
// Combinational round-robin picker. Scans the request vector starting one
// position above last_grant, wrapping at NUM_REQ, and returns the first set bit.
//   req        in   NUM_REQ  request vector
//   last_grant in   GID_W    index of the previous winner
//   pick       out  GID_W    winner index (0 when any_req=0)
//   any_req    out  1        at least one request bit is set
// -----------------------------------------------------------------------------
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int GID_W  = gid_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   last_grant,
    output logic [GID_W-1:0]   pick,
    output logic               any_req
);

    always_comb begin
        int idx;
        idx     = 0;
        pick    = '0;
        any_req = 1'b0;
        // Offsets 1..NUM_REQ: the previous winner is considered last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = GID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing the single write port of a byte FIFO among
// NUM_REQ producers. One requester owns the port for a burst of at most
// MAX_BURST beats; each grant is followed by a single IDLE arbitration cycle.
//
// Handshake: a beat transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready is only ever raised for the current
// owner in BURST and only while fifo_full is low; a producer holding valid
// must keep its data and last stable until that beat is accepted. Every
// accepted beat appears on fifo_wr/fifo_data_in in the same cycle.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   req_valid      per-requester beat valid
//   req_last       per-requester end-of-burst marker (qualified by valid)
//   req_data       packed beats, requester i at [i*DATA_W +: DATA_W]
//   req_ready      per-requester accept
//   fifo_full      FIFO full flag (backpressure)
//   fifo_wr        FIFO write enable
//   fifo_data_in   FIFO write data, zero whenever fifo_wr=0
//   grant_id       current owner, meaningful while busy=1
//   busy           high in BURST (the FSM state, visible for checkers)
//
// Build option: define FIFO_ARB_PRIO_EN to let requester 0 win every
// arbitration it takes part in, overriding the round-robin pointer.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    localparam int GID_W    = gid_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic [GID_W-1:0]          grant_id,
    output logic                      busy
);

    localparam int                 CNT_W    = cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [GID_W-1:0]   RST_LAST = GID_W'(NUM_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [GID_W-1:0]  grant_q, grant_d;
    logic [GID_W-1:0]  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [GID_W-1:0]  pick_idx;
    logic [GID_W-1:0]  win_idx;
    logic              any_req;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .pick       (pick_idx),
        .any_req    (any_req)
    );

`ifdef FIFO_ARB_PRIO_EN
    // Requester 0 jumps the queue; the pointer still advances on exit.
    assign win_idx = req_valid[0] ? '0 : pick_idx;
`else
    assign win_idx = pick_idx;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        req_ready    = '0;
        fifo_wr      = 1'b0;
        fifo_data_in = {DATA_W{DEF_DATA_BIT}};

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d    = win_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                // Outputs are gated by reset so an abandoned burst never
                // writes in the reset cycle.
                if (!reset) begin
                    req_ready[grant_q] = !fifo_full;
                end
                if (!req_valid[grant_q]) begin
                    // Owner went quiet: release without writing.
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end else if (!fifo_full) begin
                    fifo_wr      = !reset;
                    if (!reset) begin
                        fifo_data_in = req_data[int'(grant_q)*DATA_W +: DATA_W];
                    end
                    if (req_last[grant_q] || (beat_cnt_q == LAST_CNT)) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
                // fifo_full with valid: everything holds.
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= RST_LAST;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_data_in;
  logic [1:0]  grant_id;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [DATA_W-1:0] exp_q[$];

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr      (fifo_wr),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: every FIFO write must match the next expected beat
  always @(negedge clk) begin
    #2;
    if (fifo_wr === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_wr", 32'(fifo_data_in), 32'hxxxx_xxxx);
      else check("sb_wr_data", 32'(fifo_data_in), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    @(negedge clk); #1;
    check("rst_busy",  32'(busy),         0);
    check("rst_grant", 32'(grant_id),     0);
    check("rst_wr",    32'(fifo_wr),      0);
    check("rst_data",  32'(fifo_data_in), 0);
    check("rst_ready", 32'(req_ready),    0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_busy"},  32'(busy),         0);
    check({tag, "_wr"},    32'(fifo_wr),      0);
    check({tag, "_data"},  32'(fifo_data_in), 0);
    check({tag, "_ready"}, 32'(req_ready),    0);
  endtask

  task automatic chk_beat(input string tag, input int g, input logic [7:0] d);
    check({tag, "_busy"},  32'(busy),         1);
    check({tag, "_grant"}, 32'(grant_id),     32'(g));
    check({tag, "_wr"},    32'(fifo_wr),      1);
    check({tag, "_data"},  32'(fifo_data_in), 32'(d));
    check({tag, "_ready"}, 32'(req_ready),    32'(1 << g));
    exp_q.push_back(d);
  endtask

  task automatic chk_hold(input string tag, input int g, input logic [3:0] rdy);
    check({tag, "_busy"},  32'(busy),         1);
    check({tag, "_grant"}, 32'(grant_id),     32'(g));
    check({tag, "_wr"},    32'(fifo_wr),      0);
    check({tag, "_data"},  32'(fifo_data_in), 0);
    check({tag, "_ready"}, 32'(req_ready),    32'(rdy));
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;

    // 1: single requester, 4-beat burst ending with last
    do_reset();
    req_valid = 4'b0001; set_data(0, 8'hA0); #1;
    chk_idle("s1_arb");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_data(0, 8'(8'hA0 + k)); req_last = (k == 3) ? 4'b0001 : 4'b0000; #1;
      chk_beat("s1_beat", 0, 8'(8'hA0 + k));
    end
    @(negedge clk); req_valid = '0; req_last = '0; #1;
    chk_idle("s1_after");
    @(negedge clk); #1;
    chk_idle("s1_stay");

    // 2: all requesters busy, bursts capped at MAX_BURST, order 0,1,2,3,0
    do_reset();
    req_valid = 4'hf;
    for (int i = 0; i < 4; i++) set_data(i, 8'(i * 16));
    #1;
    chk_idle("s2_bubble0");
    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        set_data(r % 4, 8'((r % 4) * 16 + (r / 4) * 4 + b)); #1;
        chk_beat("s2_beat", r % 4, 8'((r % 4) * 16 + (r / 4) * 4 + b));
      end
      @(negedge clk); #1;
      chk_idle("s2_bubble");
    end

    // 3: fifo_full for 3 cycles in the middle of requester 2's burst
    do_reset();
    req_valid = 4'b0100; set_data(2, 8'h20); #1;
    chk_idle("s3_arb");
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); set_data(2, 8'(8'h20 + b)); #1;
      chk_beat("s3_pre", 2, 8'(8'h20 + b));
    end
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); fifo_full = 1'b1; set_data(2, 8'h22); #1;
      chk_hold("s3_stall", 2, 4'b0000);
    end
    for (int b = 2; b < 4; b++) begin
      @(negedge clk); fifo_full = 1'b0; set_data(2, 8'(8'h20 + b)); #1;
      chk_beat("s3_post", 2, 8'(8'h20 + b));
    end
    @(negedge clk); req_valid = '0; #1;
    chk_idle("s3_end");

    // 4: requester 1 drops valid after 2 beats, requester 2 is next
    do_reset();
    req_valid = 4'b0110; set_data(1, 8'h10); set_data(2, 8'h20); #1;
    chk_idle("s4_arb");
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); set_data(1, 8'(8'h10 + b)); #1;
      chk_beat("s4_beat", 1, 8'(8'h10 + b));
    end
    @(negedge clk); req_valid = 4'b0100; #1;
    chk_hold("s4_drop", 1, 4'b0010);
    @(negedge clk); #1;
    chk_idle("s4_bubble");
    @(negedge clk); #1;
    chk_beat("s4_next", 2, 8'h20);
    @(negedge clk); req_valid = '0; #1;
    chk_hold("s4_drop2", 2, 4'b0100);
    @(negedge clk); #1;
    chk_idle("s4_end");

    // 5: reset during the 3rd beat
    do_reset();
    req_valid = 4'b0010; set_data(1, 8'h30); #1;
    chk_idle("s5_arb");
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); set_data(1, 8'(8'h30 + b)); #1;
      chk_beat("s5_beat", 1, 8'(8'h30 + b));
    end
    @(negedge clk); set_data(1, 8'h32); reset = 1'b1; #1;
    check("s5_rst_busy",  32'(busy),         1);
    check("s5_rst_wr",    32'(fifo_wr),      0);
    check("s5_rst_data",  32'(fifo_data_in), 0);
    check("s5_rst_ready", 32'(req_ready),    0);
    @(negedge clk); reset = 1'b0; req_valid = 4'b0011; set_data(0, 8'h40); #1;
    chk_idle("s5_post_rst");
    check("s5_post_grant", 32'(grant_id), 0);
    @(negedge clk); #1;
    chk_beat("s5_first", 0, 8'h40);
    @(negedge clk); req_valid = '0; #1;
    chk_hold("s5_drop", 0, 4'b0001);
    @(negedge clk); #1;
    chk_idle("s5_end");

    // 6: last_grant=0 with requesters 0 and 1 valid
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0001; set_data(0, 8'h50); #1;
    chk_idle("s6_arb");
    @(negedge clk); #1;
    chk_beat("s6_single", 0, 8'h50);
    @(negedge clk); req_valid = 4'b0011; req_last = '0; set_data(0, 8'h51); set_data(1, 8'h60); #1;
    chk_idle("s6_bubble");
    @(negedge clk); #1;
`ifdef FIFO_ARB_PRIO_EN
    chk_beat("s6_prio", 0, 8'h51);
    @(negedge clk); req_valid = '0; #1;
    chk_hold("s6_drop", 0, 4'b0001);
`else
    chk_beat("s6_rr", 1, 8'h60);
    @(negedge clk); req_valid = '0; #1;
    chk_hold("s6_drop", 1, 4'b0010);
`endif
    @(negedge clk); #1;
    chk_idle("s6_end");

    // final report
    @(negedge clk); #3;
    check("sb_leftover", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
